// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: NUM_REQ valid/ready sources share one write port.
// Round-robin by default; define RF_WB_FIXED_PRIO_EN for fixed lowest-index priority.
`ifndef ARCH_WIDTH
`define ARCH_WIDTH 32
`endif

module rf_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int DATA_W  = `ARCH_WIDTH,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*5-1:0]      req_rd,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic                      hold,
   output logic                      rf_we,
   output logic [4:0]                rf_rd,
   output logic [DATA_W-1:0]         rf_data,
   output logic [IDX_W-1:0]          grant_id
);

   logic [NUM_REQ-1:0] gnt_oh;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_found;
   logic [4:0]         sel_rd;
   logic [DATA_W-1:0]  sel_data;
   logic               xfer;

`ifdef RF_WB_FIXED_PRIO_EN
   // Lowest-index valid requester wins; scan downward so index 0 overrides
   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req_valid[i]) begin
            gnt_oh    = '0;
            gnt_oh[i] = 1'b1;
            gnt_idx   = IDX_W'(i);
            gnt_found = 1'b1;
         end
      end
   end
`else
   logic [IDX_W-1:0] ptr;

   // Round-robin search starting just after the last granted requester
   always_comb begin
      gnt_oh    = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         int j;
         j = (int'(ptr) + k) % NUM_REQ;
         if (!gnt_found && req_valid[j]) begin
            gnt_oh[j] = 1'b1;
            gnt_idx   = IDX_W'(j);
            gnt_found = 1'b1;
         end
      end
   end

   // Pointer follows every accepted request, including rd=0 writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ptr <= IDX_W'(NUM_REQ - 1);
      else if (xfer)
         ptr <= gnt_idx;
   end
`endif

   // Ready is the grant gated by hold; never looks at rd or data
   always_comb begin
      req_ready = '0;
      if (!hold && gnt_found)
         req_ready = gnt_oh;
   end

   assign xfer = |(req_valid & req_ready);

   // One-hot mux of the winner's destination and data
   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt_oh[i]) begin
            sel_rd   = req_rd[5*i +: 5];
            sel_data = req_data[DATA_W*i +: DATA_W];
         end
      end
   end

   // Register the accepted write; rf_rd is forced to 0 whenever rf_we is low
   // because reg_file bypasses on any nonzero rd match
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_rd    <= '0;
         rf_data  <= '0;
         grant_id <= '0;
      end else if (xfer) begin
         rf_we    <= (sel_rd != 5'd0);
         rf_rd    <= sel_rd;
         rf_data  <= sel_data;
         grant_id <= gnt_idx;
      end else begin
         rf_we <= 1'b0;
         rf_rd <= '0;
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter (NUM_REQ=3, DATA_W=32).
// Each scenario task drives vectors and checks hand-computed results inline.
module tb_rf_wb_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int IW = 2;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*5-1:0]  req_rd;
   logic [N*DW-1:0] req_data;
   logic            hold;
   logic            rf_we;
   logic [4:0]      rf_rd;
   logic [DW-1:0]   rf_data;
   logic [IW-1:0]   grant_id;

   int checks;
   int errors;

   rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_rd    (req_rd),
      .req_data  (req_data),
      .hold      (hold),
      .rf_we     (rf_we),
      .rf_rd     (rf_rd),
      .rf_data   (rf_data),
      .grant_id  (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_req(input int i, input logic [4:0] rd,
                          input logic [DW-1:0] d);
      req_rd[5*i +: 5]    = rd;
      req_data[DW*i +: DW] = d;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst       = 1'b0;
      req_valid = '0;
      req_rd    = '0;
      req_data  = '0;
      hold      = 1'b0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      set_req(0, 5'd7, 32'hAAAA_0000);
      set_req(1, 5'd8, 32'hBBBB_0000);
      set_req(2, 5'd9, 32'hCCCC_0000);
      req_valid = 3'b110;
      @(posedge clk); #1;
      @(posedge clk); #1;
      // traffic in flight: async reset between edges
      #2 rst = 1'b0;
      #1;
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== 5'd0) begin
         errors++;
         $display("FAIL reset_we_rd: got we=%b rd=%0d want 0 0", rf_we, rf_rd);
      end
      checks++;
      if (rf_data !== 32'd0 || grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_data_gid: got data=%h gid=%0d want 0 0",
                  rf_data, grant_id);
      end
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 3'b111;
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++;
         $display("FAIL reset_first_ready: got %b want 001", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (grant_id !== 2'd0 || rf_we !== 1'b1 || rf_rd !== 5'd7) begin
         errors++;
         $display("FAIL reset_first_grant: got gid=%0d we=%b rd=%0d want 0 1 7",
                  grant_id, rf_we, rf_rd);
      end
      req_valid = '0;
   endtask

   task automatic test_single_write();
      apply_reset();
      set_req(1, 5'd5, 32'h0000_1234);
      req_valid = 3'b010;
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++;
         $display("FAIL single_ready: got %b want 010", req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_data !== 32'h1234
          || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL single_write: got we=%b rd=%0d data=%h gid=%0d want 1 5 1234 1",
                  rf_we, rf_rd, rf_data, grant_id);
      end
      @(posedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_data !== 32'h1234
          || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL single_idle: got we=%b rd=%0d data=%h gid=%0d want 0 0 1234 1",
                  rf_we, rf_rd, rf_data, grant_id);
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      set_req(0, 5'd1, 32'hA0);
      set_req(1, 5'd2, 32'hA1);
      set_req(2, 5'd3, 32'hA2);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         logic [N-1:0] exp_rdy;
         exp_rdy = 3'b001 << (k % 3);
         #1;
         checks++;
         if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rr_ready[%0d]: got %b want %b", k, req_ready, exp_rdy);
         end
         @(posedge clk); #1;
         checks++;
         if (grant_id !== IW'(k % 3) || rf_we !== 1'b1
             || rf_rd !== 5'(k % 3 + 1) || rf_data !== 32'(32'hA0 + k % 3)) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got gid=%0d we=%b rd=%0d data=%h want %0d 1 %0d %h",
                     k, grant_id, rf_we, rf_rd, rf_data, k % 3, k % 3 + 1,
                     32'hA0 + k % 3);
         end
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   task automatic test_x0_write();
      apply_reset();
      set_req(0, 5'd10, 32'h10);
      set_req(1, 5'd11, 32'h11);
      set_req(2, 5'd0,  32'hFFFF);
      // grant requester 1 first so ptr=1
      req_valid = 3'b010;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 3'b100;
      #1;
      checks++;
      if (req_ready !== 3'b100) begin
         errors++;
         $display("FAIL x0_ready: got %b want 100", req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (rf_we !== 1'b0 || rf_rd !== 5'd0) begin
         errors++;
         $display("FAIL x0_write: got we=%b rd=%0d want 0 0", rf_we, rf_rd);
      end
      @(negedge clk);
      set_req(2, 5'd12, 32'h12);
      req_valid = 3'b111;
      #1;
      checks++;
      if (req_ready !== 3'b001) begin
         errors++;
         $display("FAIL x0_ptr_adv: got ready %b want 001", req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
   endtask

   task automatic test_hold();
      apply_reset();
      set_req(0, 5'd20, 32'h20);
      set_req(1, 5'd21, 32'h21);
      // grant requester 0 so ptr=0
      req_valid = 3'b001;
      @(posedge clk); #1;
      @(negedge clk);
      req_valid = 3'b011;
      hold      = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL hold_ready[%0d]: got %b want 000", k, req_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (rf_we !== 1'b0 || rf_rd !== 5'd0) begin
            errors++;
            $display("FAIL hold_we[%0d]: got we=%b rd=%0d want 0 0", k, rf_we, rf_rd);
         end
         @(negedge clk);
      end
      hold = 1'b0;
      #1;
      checks++;
      if (req_ready !== 3'b010) begin
         errors++;
         $display("FAIL hold_release_ready: got %b want 010", req_ready);
      end
      @(posedge clk); #1;
      req_valid = '0;
      checks++;
      if (rf_we !== 1'b1 || rf_rd !== 5'd21 || grant_id !== 2'd1) begin
         errors++;
         $display("FAIL hold_release_write: got we=%b rd=%0d gid=%0d want 1 21 1",
                  rf_we, rf_rd, grant_id);
      end
   endtask

   task automatic test_fixed_prio();
      apply_reset();
      set_req(0, 5'd1, 32'hB0);
      set_req(1, 5'd2, 32'hB1);
      set_req(2, 5'd3, 32'hB2);
      req_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++;
         if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL fp_ready[%0d]: got %b want 001", k, req_ready);
         end
         @(posedge clk); #1;
         checks++;
         if (grant_id !== 2'd0 || rf_we !== 1'b1 || rf_rd !== 5'd1) begin
            errors++;
            $display("FAIL fp_grant[%0d]: got gid=%0d we=%b rd=%0d want 0 1 1",
                     k, grant_id, rf_we, rf_rd);
         end
         @(negedge clk);
      end
      req_valid = '0;
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      req_valid = '0;
      req_rd    = '0;
      req_data  = '0;
      hold      = 1'b0;
      test_reset();
      test_single_write();
`ifdef RF_WB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_x0_write();
      test_hold();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port (we, rd, data_in) among NUM_REQ writeback requesters, e.g. ALU, load unit and mul/div.
- Uses a valid/ready handshake per requester and round-robin arbitration.
- Registers the winning write for one cycle before presenting it to the register file.
- Sits between the execute/memory writeback sources and reg_file.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_W, `ARCH_WIDTH, register data width.
- IDX_W, $clog2(NUM_REQ), width of grant index.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  one clock; reset is asynchronous and active-low (rst=0 resets immediately, independent of clk).
- req_valid  input  NUM_REQ  bit i: requester i has a write pending.
- req_ready  output  NUM_REQ  bit i: write from requester i accepted this cycle (one-hot or zero).
- req_rd  input  NUM_REQ*5  destination register of requester i, slice [5i+4:5i].
- req_data  input  NUM_REQ*DATA_W  write data of requester i, slice [DATA_W*i +: DATA_W].
- hold  input  1  freeze arbitration (writeback stall); no request accepted while 1.
- rf_we  output  1  register-file write enable.
- rf_rd  output  5  register-file destination index.
- rf_data  output  DATA_W  register-file write data.
- grant_id  output  IDX_W  index of the requester whose write is on rf_*.

Behaviour:
- Reset (rst=0, async):
  - rf_we=0, rf_rd=0, rf_data=0, grant_id=0.
  - Round-robin pointer ptr=NUM_REQ-1, so the first grant after reset goes to requester 0.
- Arbitration (combinational, every cycle):
  - If hold=1 or no req_valid, req_ready=0.
  - Otherwise grant g = first i with req_valid[i], searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ready[g]=1; all other ready bits 0.
  - req_ready never depends on req_rd or req_data.
- Transfer: occurs when req_valid[g] & req_ready[g]. On the next posedge:
  - rf_rd <= req_rd[g]; rf_data <= req_data[g]; grant_id <= g; ptr <= g.
  - rf_we <= (req_rd[g] != 0).
- Latency: exactly 1 cycle from accept to rf_we; throughput one write per cycle.
- No transfer in a cycle (idle or hold=1):
  - Next posedge: rf_we<=0 and rf_rd<=0; rf_data and grant_id keep their values; ptr unchanged.
- rf_rd is 0 whenever rf_we=0. This is mandatory: reg_file bypasses data_in on any nonzero rd match regardless of we.
- rd=0 requests are accepted (ready=1), consume their arbitration slot and advance ptr, but produce rf_we=0, rf_rd=0.
- Requester rule: once req_valid is asserted, rd and data stay stable and valid stays high until ready. The arbiter tolerates valid dropping without ready; that request is simply not granted.
- Fairness: a continuously valid requester is granted within NUM_REQ transfer cycles.
- Same rd from several requesters in one cycle: writes are issued in grant order; the last write wins in the register file.
- Reset mid-operation: an accepted but not yet written request is dropped. Requesters handle this by also being reset.

Optional Feature:
- Macro RF_WB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest index valid requester always wins; ptr is removed; starvation of higher indices is allowed.
- Undefined: round-robin as specified above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: drive valid traffic, pull rst=0 between clock edges -> rf_we=0, rf_rd=0, rf_data=0, grant_id=0 immediately. Release rst, all three valid -> first grant is requester 0.
- Single write: req_valid=3'b010, rd1=5, data1=0x1234 -> req_ready=3'b010 the same cycle. Next cycle rf_we=1, rf_rd=5, rf_data=0x1234, grant_id=1. Following idle cycle rf_we=0, rf_rd=0.
- Round-robin: all three valid for 6 cycles, distinct rd 1/2/3 -> grant_id sequence 0,1,2,0,1,2 and rf_we high every cycle.
- x0 write: requester 2 valid with rd=0, data=0xFFFF -> req_ready[2]=1, next cycle rf_we=0, rf_rd=0; ptr advanced, so the next contention grants requester 0.
- Hold: requesters 0 and 1 valid, hold=1 for 3 cycles -> req_ready=0 and rf_we=0 throughout. Release hold -> requester granted per ptr, written 1 cycle later.
- RF_WB_FIXED_PRIO_EN defined, all three valid for 4 cycles -> grant_id=0 every cycle and req_ready[1]=req_ready[2]=0 throughout.
